booth_r8_mac: RTL and testbench

- Parametrised iterative radix-8 Booth multiply-accumulate unit for iCE40-class fabric; successor to the fixed 8-bit Booth core.
- Operand width is a parameter, each operand has independent signed/unsigned mode, and a signed accumulator with sticky overflow is built in.
- Uses valid/ready handshakes on both input and output, so it sits directly in streaming DSP datapaths. The result holds under backpressure.

---
 rtl/booth_r8_pkg.sv | 19 +
 rtl/booth_r8_recode.sv | 28 ++
 rtl/booth_r8_mac.sv | 159 +++++++++++++++
 tb/tb_booth_r8_mac.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/booth_r8_pkg.sv
// rtl/booth_r8_pkg.sv - shared state encoding and sizing helpers for the radix-8 Booth MAC
package booth_r8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ACC  = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Guard bits above the operand so that +/-4x never overflows the partial sum
  localparam int PS_GUARD = 3;

  // Radix-8 digits needed to cover WIDTH bits plus a sign position: ceil((w+1)/3)
  function automatic int niter(input int w);
    return (w + 3) / 3;
  endfunction

endpackage

// File: rtl/booth_r8_recode.sv
// rtl/booth_r8_recode.sv - radix-8 Booth digit recoder: 4 overlapping bits to one-hot magnitude plus sign
module booth_r8_recode (
  input  logic [3:0] bits_i,
  output logic       sel_1x_o,
  output logic       sel_2x_o,
  output logic       sel_3x_o,
  output logic       sel_4x_o,
  output logic       inv_o
);

  always_comb begin
    sel_1x_o = 1'b0;
    sel_2x_o = 1'b0;
    sel_3x_o = 1'b0;
    sel_4x_o = 1'b0;
    unique case (bits_i)
      4'b0001, 4'b0010, 4'b1101, 4'b1110: sel_1x_o = 1'b1;
      4'b0011, 4'b0100, 4'b1011, 4'b1100: sel_2x_o = 1'b1;
      4'b0101, 4'b0110, 4'b1001, 4'b1010: sel_3x_o = 1'b1;
      4'b0111, 4'b1000:                   sel_4x_o = 1'b1;
      default: ;
    endcase
  end

  // Digit 0 for 1111 still negates cleanly: ~0 + 1 wraps to 0
  assign inv_o = bits_i[3];

endmodule

// File: rtl/booth_r8_mac.sv
// rtl/booth_r8_mac.sv - iterative radix-8 Booth multiply-accumulate with valid/ready on both sides
module booth_r8_mac
  import booth_r8_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 2*WIDTH+8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [1:0]           sign_mode,
  input  logic                 acc_en,
  input  logic                 acc_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 acc_ovf,
  output logic                 busy
);

  localparam int NIT = niter(WIDTH);
  localparam int MW  = 3*NIT;
  localparam int PSW = WIDTH + PS_GUARD;
  localparam int PW  = 2*WIDTH;
  localparam int CW  = $clog2(NIT+1);

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [PSW-1:0]         a_q, a_d, a3_q, a3_d, psum_q, psum_d;
  logic [MW:0]            mreg_q, mreg_d;
  logic [1:0]             mode_q, mode_d;
  logic                   en_q, en_d, clr_q, clr_d, ovf_q, ovf_d;
  logic [PW-1:0]          prod_q, prod_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;

  logic [PSW-1:0]         a_ext;
  logic [MW:0]            b_ext;
  logic                   s1, s2, s3, s4, inv;
  logic [PSW:0]           mag, sum;
  logic [PW-1:0]          prod_res;
  logic [ACC_WIDTH-1:0]   ext, acc_sum;
  logic                   add_ovf;

  assign a_ext = {{PS_GUARD{sign_mode[1] & multiplicand[WIDTH-1]}}, multiplicand};
  // Bit 0 is the implicit zero below the multiplier LSB
  assign b_ext = {{(MW-WIDTH){sign_mode[0] & multiplier[WIDTH-1]}}, multiplier, 1'b0};

  booth_r8_recode u_recode (
    .bits_i   (mreg_q[3:0]),
    .sel_1x_o (s1),
    .sel_2x_o (s2),
    .sel_3x_o (s3),
    .sel_4x_o (s4),
    .inv_o    (inv)
  );

  assign mag = ({(PSW+1){s1}} & {a_q[PSW-1], a_q})
             | ({(PSW+1){s2}} & {a_q, 1'b0})
             | ({(PSW+1){s3}} & {a3_q[PSW-1], a3_q})
             | ({(PSW+1){s4}} & {a_q[PSW-2:0], 2'b00});
  // One extra bit absorbs the transient sum; it shrinks back into PSW after the shift
  assign sum = {psum_q[PSW-1], psum_q} + (mag ^ {(PSW+1){inv}}) + {{PSW{1'b0}}, inv};

  assign prod_res = {psum_q[PW-MW-1:0], mreg_q[MW:1]};
  assign ext      = (mode_q != 2'b00) ? {{(ACC_WIDTH-PW){prod_res[PW-1]}}, prod_res}
                                      : {{(ACC_WIDTH-PW){1'b0}}, prod_res};
  assign acc_sum  = acc_q + ext;
  assign add_ovf  = (acc_q[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
                    (acc_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    a3_d    = a3_q;
    psum_d  = psum_q;
    mreg_d  = mreg_q;
    mode_d  = mode_q;
    en_d    = en_q;
    clr_d   = clr_q;
    prod_d  = prod_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a_ext;
        a3_d    = a_ext + {a_ext[PSW-2:0], 1'b0};
        psum_d  = '0;
        mreg_d  = b_ext;
        mode_d  = sign_mode;
        en_d    = acc_en;
        clr_d   = acc_clr;
        cnt_d   = CW'(NIT);
        state_d = CALC;
      end
      CALC: begin
        psum_d = {{2{sum[PSW]}}, sum[PSW:3]};
        mreg_d = {sum[2:0], mreg_q[MW:3]};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = ACC;
      end
      ACC: begin
        prod_d = prod_res;
        if (clr_q) begin
          acc_d = ext;
          ovf_d = 1'b0;
        end else if (en_q) begin
          acc_d = acc_sum;
          ovf_d = ovf_q | add_ovf;
        end
        state_d = HOLD;
      end
      HOLD: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      a3_q    <= '0;
      psum_q  <= '0;
      mreg_q  <= '0;
      mode_q  <= '0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      prod_q  <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      a3_q    <= a3_d;
      psum_q  <= psum_d;
      mreg_q  <= mreg_d;
      mode_q  <= mode_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign product   = prod_q;
  assign acc_out   = acc_q;
  assign acc_ovf   = ovf_q;

endmodule

// File: tb/tb_booth_r8_mac.sv
// tb/tb_booth_r8_mac.sv - scoreboard bench for booth_r8_mac (WIDTH=16, ACC_WIDTH=33)
module tb_booth_r8_mac;

  localparam int W  = 16;
  localparam int AW = 33;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  multiplicand = '0;
  logic [W-1:0]  multiplier = '0;
  logic [1:0]    sign_mode = '0;
  logic          acc_en = 1'b0;
  logic          acc_clr = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [2*W-1:0] product;
  logic [AW-1:0] acc_out;
  logic          acc_ovf;
  logic          busy;

  always #5 clk = ~clk;

  booth_r8_mac #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .multiplicand(multiplicand), .multiplier(multiplier), .sign_mode(sign_mode),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .acc_out(acc_out), .acc_ovf(acc_ovf), .busy(busy)
  );

  typedef struct packed {
    logic [31:0] prod;
    logic [32:0] acc;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  exp_t        last_exp;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [32:0] acc_m = '0;
  logic        ovf_m = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [15:0] b, input logic [1:0] mode,
                          input logic en, input logic clr);
    exp_t        e;
    longint      ax, bx, p;
    logic [32:0] ext, s;
    ax = mode[1] ? longint'($signed(a)) : longint'(a);
    bx = mode[0] ? longint'($signed(b)) : longint'(b);
    p  = ax * bx;
    e.prod = p[31:0];
    ext = (mode != 2'b00) ? {e.prod[31], e.prod} : {1'b0, e.prod};
    if (clr) begin
      acc_m = ext;
      ovf_m = 1'b0;
    end else if (en) begin
      s = acc_m + ext;
      if (acc_m[32] == ext[32] && s[32] != acc_m[32]) ovf_m = 1'b1;
      acc_m = s;
    end
    e.acc = acc_m;
    e.ovf = ovf_m;
    sb.push_back(e);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] mode,
                        input logic en, input logic clr, input string tag);
    int   lat;
    exp_t e;
    @(negedge clk);
    multiplicand = a; multiplier = b; sign_mode = mode; acc_en = en; acc_clr = clr;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    check({tag, "_rdy"}, in_ready, 1);
    @(posedge clk);
    push_exp(a, b, mode, en, clr);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, 7);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      last_exp = e;
      check({tag, "_prod"}, product, e.prod);
      check({tag, "_acc"}, acc_out, e.acc);
      check({tag, "_ovf"}, acc_ovf, e.ovf);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] ra, rb;
    logic [1:0]  rm;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", product, 0);
    check("rst_acc", acc_out, 0);
    check("rst_ovf", acc_ovf, 0);
    @(negedge clk) rst_n = 1'b1;

    run_op(16'hFFFF, 16'hFFFF, 2'b00, 0, 0, "umax");
    run_op(16'h8000, 16'h8000, 2'b11, 0, 0, "smin_sq");
    run_op(16'h8000, 16'h7FFF, 2'b11, 0, 0, "smin_max");
    run_op(16'hFFFF, 16'hFFFF, 2'b10, 0, 0, "mix_as");
    run_op(16'hFFFF, 16'hFFFF, 2'b01, 0, 0, "mix_bs");

    run_op(16'd3, 16'd4, 2'b00, 0, 1, "mac_clr");
    run_op(16'd5, 16'd6, 2'b00, 1, 0, "mac_add");
    run_op(16'hFFF9, 16'd2, 2'b11, 1, 0, "mac_neg");
    run_op(16'd1, 16'd1, 2'b00, 0, 0, "mac_hold");

    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rm = 2'($urandom_range(0, 3));
      run_op(ra, rb, rm, 1'($urandom_range(0, 1)), 1'(i == 0), "rand");
    end

    run_op(16'h7FFF, 16'h7FFF, 2'b11, 0, 1, "ovf_clr");
    for (int i = 0; i < 5; i++) run_op(16'h7FFF, 16'h7FFF, 2'b11, 1, 0, "ovf_add");
    run_op(16'h0002, 16'h0003, 2'b11, 0, 1, "ovf_reclr");

    out_ready = 1'b0;
    run_op(16'h1234, 16'h0056, 2'b00, 0, 0, "bp");
    @(negedge clk);
    multiplicand = 16'h0BCD; multiplier = 16'h0EF0; sign_mode = 2'b00; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_prod_stable", product, last_exp.prod);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_idle", in_ready, 1);
    run_op(16'h0BCD, 16'h0EF0, 2'b00, 0, 0, "bp_next");

    @(negedge clk);
    multiplicand = 16'h4321; multiplier = 16'h1111; sign_mode = 2'b11; acc_en = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    acc_m = '0; ovf_m = 1'b0;
    check("arst_in_ready", in_ready, 1);
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_product", product, 0);
    check("arst_acc", acc_out, 0);
    check("arst_ovf", acc_ovf, 0);
    @(negedge clk) rst_n = 1'b1;
    run_op(16'hFF00, 16'h0123, 2'b11, 1, 0, "post_rst");

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
